// File: rtl/obi_loader_bridge.sv
// obi_loader_bridge
//
// Moves MCU-supplied words onto an X-HEEP OBI master port. Words arrive as
// single-cycle pulses and wait in a small FIFO. Each word is written to the
// next address of an auto-incrementing counter that can be loaded with a new
// base. A read-back mode fetches N consecutive words so a loaded program can
// be verified.
//
// Ports
//   clk, rst               : clock; asynchronous active-high reset
//   req, we, be, addr,
//   wdata                  : OBI request channel (all registered, be fixed all-ones)
//   gnt, rvalid, rdata     : OBI grant and response channel
//   instr_valid,
//   instruction            : push one word into the write FIFO
//   addr_valid,
//   new_section_address    : load the address counter (only while not busy)
//   rd_start, rd_count     : start read-back of rd_count words (only while not busy)
//   busy                   : FSM active, FIFO non-empty or read-back pending
//   fifo_full              : FIFO holds FIFO_DEPTH words
//   overflow               : sticky, a push was dropped; cleared by accepted addr_valid
//   OBI_rvalid, OBI_rdata  : one-cycle pulse per read-back word, data held until next pulse

module obi_loader_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req,
    output logic                  we,
    output logic [DATA_W/8-1:0]   be,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wdata,
    input  logic                  gnt,
    input  logic                  rvalid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  instr_valid,
    input  logic [DATA_W-1:0]     instruction,
    input  logic                  addr_valid,
    input  logic [ADDR_W-1:0]     new_section_address,
    input  logic                  rd_start,
    input  logic [CNT_W-1:0]      rd_count,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  OBI_rvalid,
    output logic [DATA_W-1:0]     OBI_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RRESP = 3'd4
    } state_t;

    state_t               state_r;
    logic [DATA_W-1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [FCNT_W-1:0]    fifo_cnt_r;
    logic [ADDR_W-1:0]    addr_cnt_r;
    logic [CNT_W-1:0]     rd_remain_r;
    logic                 req_r;
    logic                 we_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [DATA_W-1:0]    wdata_r;
    logic                 overflow_r;
    logic                 obi_rvalid_r;
    logic [DATA_W-1:0]    obi_rdata_r;

    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 idle_s;
    logic                 accept_addr_s;
    logic                 accept_rd_s;
    logic [ADDR_W-1:0]    addr_next_s;
    logic [CNT_W-1:0]     remain_dec_s;

    // Handshake decode: all terms come from registered state plus the current inputs
    always_comb begin
        fifo_empty_s  = (fifo_cnt_r == '0);
        // Push decision uses the pre-edge count only, so a same-cycle pop never makes room
        push_s        = instr_valid && (fifo_cnt_r < DEPTH_C);
        drop_s        = instr_valid && !(fifo_cnt_r < DEPTH_C);
        pop_s         = (state_r == WREQ) && gnt;
        idle_s        = (state_r == IDLE) && fifo_empty_s && (rd_remain_r == '0);
        accept_addr_s = addr_valid && idle_s;
        accept_rd_s   = rd_start && idle_s;
        addr_next_s   = addr_cnt_r + STRIDE_C;
        remain_dec_s  = rd_remain_r - CNT_W'(1);
    end

    // FIFO storage; occupancy is tracked by the counter, so the array needs no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= instruction;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + FCNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - FCNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (accept_addr_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Transfer FSM with registered OBI request outputs and read-back capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            addr_cnt_r   <= '0;
            rd_remain_r  <= '0;
            obi_rvalid_r <= 1'b0;
            obi_rdata_r  <= '0;
        end else begin
            obi_rvalid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_addr_s) begin
                        addr_cnt_r <= new_section_address;
                    end else begin
                        addr_cnt_r <= addr_cnt_r;
                    end
                    if (accept_rd_s) begin
                        rd_remain_r <= rd_count;
                    end else begin
                        rd_remain_r <= rd_remain_r;
                    end
                    // Queued writes win over a pending read-back
                    if (!fifo_empty_s) begin
                        state_r <= WREQ;
                        req_r   <= 1'b1;
                        we_r    <= 1'b1;
                        addr_r  <= addr_cnt_r;
                        wdata_r <= fifo_mem_r[rd_ptr_r];
                    end else if (rd_remain_r != '0) begin
                        state_r <= RREQ;
                        req_r   <= 1'b1;
                        we_r    <= 1'b0;
                        addr_r  <= addr_cnt_r;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WREQ: begin
                    if (gnt) begin
                        req_r   <= 1'b0;
                        state_r <= WRESP;
                    end else begin
                        state_r <= WREQ;
                    end
                end
                WRESP: begin
                    if (rvalid) begin
                        addr_cnt_r <= addr_next_s;
                        // Pop already happened at grant, so the head is the next word
                        if (!fifo_empty_s) begin
                            state_r <= WREQ;
                            req_r   <= 1'b1;
                            we_r    <= 1'b1;
                            addr_r  <= addr_next_s;
                            wdata_r <= fifo_mem_r[rd_ptr_r];
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= WRESP;
                    end
                end
                RREQ: begin
                    if (gnt) begin
                        req_r   <= 1'b0;
                        state_r <= RRESP;
                    end else begin
                        state_r <= RREQ;
                    end
                end
                RRESP: begin
                    if (rvalid) begin
                        obi_rdata_r  <= rdata;
                        obi_rvalid_r <= 1'b1;
                        addr_cnt_r   <= addr_next_s;
                        rd_remain_r  <= remain_dec_s;
                        if (remain_dec_s != '0) begin
                            state_r <= RREQ;
                            req_r   <= 1'b1;
                            we_r    <= 1'b0;
                            addr_r  <= addr_next_s;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= RRESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req        = req_r;
    assign we         = we_r;
    assign be         = '1;
    assign addr       = addr_r;
    assign wdata      = wdata_r;
    assign busy       = !idle_s;
    assign fifo_full  = (fifo_cnt_r == DEPTH_C);
    assign overflow   = overflow_r;
    assign OBI_rvalid = obi_rvalid_r;
    assign OBI_rdata  = obi_rdata_r;

endmodule

// File: tb/tb_obi_loader_bridge.sv
// Self-checking bench for obi_loader_bridge: an OBI memory responder with
// configurable grant/response delays, a transaction-level reference model
// (address counter, expected write/read list, reference memory) and
// randomized write/read-back rounds plus directed boundary cases.

module tb_obi_loader_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        addr_valid;
    logic [31:0] new_section_address;
    logic        rd_start;
    logic [15:0] rd_count;
    logic        busy, fifo_full, overflow, OBI_rvalid;
    logic [31:0] OBI_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    obi_loader_bridge #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .instr_valid(instr_valid), .instruction(instruction),
        .addr_valid(addr_valid), .new_section_address(new_section_address),
        .rd_start(rd_start), .rd_count(rd_count),
        .busy(busy), .fifo_full(fifo_full), .overflow(overflow),
        .OBI_rvalid(OBI_rvalid), .OBI_rdata(OBI_rdata)
    );

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Contents of never-written memory locations
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- OBI memory responder ----------------
    int          gnt_delay = 0;
    int          rvalid_delay = 0;
    bit          gnt_hold = 1'b0;
    bit          in_req = 1'b0;
    bit          resp_pending = 1'b0;
    int          wait_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] resp_data;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [31:0] mem [logic [31:0]];
    logic [64:0] obs_q [$];

    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            gnt = 1'b0; rvalid = 1'b0; rdata = $urandom();
            if (resp_pending) begin
                check_eq("single_outstanding", {95'h0, req}, 96'h0);
                if (resp_cnt == 0) begin
                    rvalid = 1'b1;
                    rdata = resp_data;
                    resp_pending = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end else if (req === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1; wait_cnt = gnt_delay;
                    cap_addr = addr; cap_we = we; cap_wdata = wdata;
                end else begin
                    check_eq("addr_stable", addr, cap_addr);
                    check_eq("we_stable", we, cap_we);
                    if (cap_we) check_eq("wdata_stable", wdata, cap_wdata);
                end
                if (!gnt_hold && wait_cnt == 0) begin
                    gnt = 1'b1;
                    in_req = 1'b0;
                    check_eq("be", be, 96'hF);
                    if (cap_we) begin
                        mem[cap_addr] = cap_wdata;
                        obs_q.push_back({1'b1, cap_addr, cap_wdata});
                        resp_data = 32'h0;
                    end else begin
                        obs_q.push_back({1'b0, cap_addr, 32'h0});
                        resp_data = mem.exists(cap_addr) ? mem[cap_addr] : dflt(cap_addr);
                    end
                    resp_pending = 1'b1;
                    resp_cnt = rvalid_delay;
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- read-back monitor ----------------
    logic [31:0] obs_rd [$];
    initial begin
        forever begin
            @(posedge clk); #1;
            if (OBI_rvalid === 1'b1) obs_rd.push_back(OBI_rdata);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] model_addr = 32'h0;
    logic [64:0] exp_q [$];
    logic [31:0] exp_rd [$];
    logic [31:0] ref_mem [logic [31:0]];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_write(input logic [31:0] w);
        exp_q.push_back({1'b1, model_addr, w});
        ref_mem[model_addr] = w;
        model_addr = model_addr + 32'd4;
    endtask

    task automatic push_raw(input logic [31:0] w);
        instr_valid = 1'b1; instruction = w;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        int g = 0;
        while (fifo_full === 1'b1 && g < 200) begin tick(); g++; end
        if (g >= 200) check_eq("full_timeout", {95'h0, fifo_full}, 96'h0);
        push_raw(w);
        model_write(w);
    endtask

    task automatic set_base(input logic [31:0] b);
        addr_valid = 1'b1; new_section_address = b;
        tick();
        addr_valid = 1'b0;
        model_addr = b;
    endtask

    // Base load and read start in the same idle cycle
    task automatic start_read(input logic [31:0] b, input int n);
        addr_valid = 1'b1; new_section_address = b;
        rd_start = 1'b1; rd_count = 16'(n);
        tick();
        addr_valid = 1'b0; rd_start = 1'b0;
        model_addr = b;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, model_addr, 32'h0});
            exp_rd.push_back(ref_mem.exists(model_addr) ? ref_mem[model_addr] : dflt(model_addr));
            model_addr = model_addr + 32'd4;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int i = 0;
        while ((busy !== 1'b0 || resp_pending) && i < max_cycles) begin tick(); i++; end
        check_eq("idle_reached", {95'h0, busy}, 96'h0);
    endtask

    task automatic compare_all(input string tag);
        tick();
        check_eq({tag, "_txn_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_txn%0d", tag, i), obs_q[i], exp_q[i]);
        check_eq({tag, "_rd_count"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
            check_eq($sformatf("%s_rd%0d", tag, i), obs_rd[i], exp_rd[i]);
        obs_q.delete(); exp_q.delete(); obs_rd.delete(); exp_rd.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"}, {95'h0, req}, 96'h0);
        check_eq({tag, "_we"}, {95'h0, we}, 96'h0);
        check_eq({tag, "_be"}, be, 96'hF);
        check_eq({tag, "_addr"}, addr, 96'h0);
        check_eq({tag, "_wdata"}, wdata, 96'h0);
        check_eq({tag, "_busy"}, {95'h0, busy}, 96'h0);
        check_eq({tag, "_fifo_full"}, {95'h0, fifo_full}, 96'h0);
        check_eq({tag, "_overflow"}, {95'h0, overflow}, 96'h0);
        check_eq({tag, "_obi_rvalid"}, {95'h0, OBI_rvalid}, 96'h0);
        check_eq({tag, "_obi_rdata"}, OBI_rdata, 96'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int n;
        rst = 1'b1; instr_valid = 1'b0; instruction = 32'h0;
        addr_valid = 1'b0; new_section_address = 32'h0;
        rd_start = 1'b0; rd_count = 16'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Single word, zero-wait memory: exact cycle timing
        set_base(32'h0000_0180);
        push_raw(32'hDEAD_BEEF);
        model_write(32'hDEAD_BEEF);
        check_eq("push_busy", {95'h0, busy}, 96'h1);
        check_eq("push_req_low", {95'h0, req}, 96'h0);
        tick();
        check_eq("wreq_req", {95'h0, req}, 96'h1);
        check_eq("wreq_we", {95'h0, we}, 96'h1);
        check_eq("wreq_addr", addr, 96'h180);
        check_eq("wreq_wdata", wdata, 96'hDEAD_BEEF);
        tick();
        check_eq("wresp_req", {95'h0, req}, 96'h0);
        check_eq("wresp_busy", {95'h0, busy}, 96'h1);
        tick();
        check_eq("done_busy", {95'h0, busy}, 96'h0);
        compare_all("single");

        // Fill FIFO with grant withheld, then overflow
        set_base(32'h0000_2000);
        gnt_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_raw(32'h1111_0000 + 32'(i));
            model_write(32'h1111_0000 + 32'(i));
        end
        check_eq("full_set", {95'h0, fifo_full}, 96'h1);
        check_eq("ovf_clear", {95'h0, overflow}, 96'h0);
        push_raw(32'hBAD0_BAD0);
        check_eq("ovf_set", {95'h0, overflow}, 96'h1);
        check_eq("full_held", {95'h0, fifo_full}, 96'h1);
        addr_valid = 1'b1; new_section_address = 32'h0000_9990;
        tick();
        addr_valid = 1'b0;
        check_eq("ovf_sticky_busy", {95'h0, overflow}, 96'h1);
        repeat (3) tick();
        gnt_hold = 1'b0;
        wait_idle(100);
        compare_all("fill");
        check_eq("ovf_before_clear", {95'h0, overflow}, 96'h1);
        set_base(32'h0000_3000);
        check_eq("ovf_cleared", {95'h0, overflow}, 96'h0);

        // Address wrap
        gnt_delay = 2; rvalid_delay = 1;
        set_base(32'hFFFF_FFFC);
        push_word(32'hCAFE_0001);
        push_word(32'hCAFE_0002);
        wait_idle(100);
        compare_all("wrap");

        // Read-back of three words at 0x100
        gnt_delay = 0; rvalid_delay = 0;
        set_base(32'h0000_0100);
        push_word(32'h0000_000A);
        push_word(32'h0000_000B);
        push_word(32'h0000_000C);
        wait_idle(100);
        compare_all("load_abc");
        start_read(32'h0000_0100, 3);
        wait_idle(100);
        compare_all("read_abc");

        // rd_count of zero issues nothing
        start_read(32'h0000_0500, 0);
        check_eq("rd0_busy", {95'h0, busy}, 96'h0);
        repeat (4) tick();
        compare_all("read_zero");

        // Randomized write/read-back rounds
        for (int it = 0; it < 6; it++) begin
            gnt_delay = $urandom_range(0, 3);
            rvalid_delay = $urandom_range(0, 2);
            base = $urandom() & 32'hFFFF_FFFC;
            if (it == 0) base = 32'hFFFF_FFF0;
            n = $urandom_range(1, 8);
            set_base(base);
            for (int j = 0; j < n; j++) begin
                push_word($urandom());
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle(400);
            compare_all($sformatf("rnd%0d_wr", it));
            start_read(base, n);
            wait_idle(400);
            compare_all($sformatf("rnd%0d_rd", it));
        end

        // Reset during WRESP with two words still queued
        gnt_delay = 0; rvalid_delay = 3;
        set_base(32'h0000_0040);
        push_raw(32'h5555_0001);
        model_write(32'h5555_0001);
        push_raw(32'h5555_0002);
        push_raw(32'h5555_0003);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        model_addr = 32'h0;
        repeat (6) tick();
        check_eq("midrst_late_busy", {95'h0, busy}, 96'h0);
        check_eq("midrst_no_fwd", obs_rd.size(), 96'h0);
        rvalid_delay = 0;
        push_word(32'h7777_0000);
        wait_idle(100);
        compare_all("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obi_loader_bridge.md
# obi_loader_bridge

Parametrised MCU-to-X-HEEP loader bridge; successor of the single-word instruction bridge. It sits between the CW305 MCU-facing register block and an X-HEEP OBI master port. MCU words are buffered in a FIFO and written to consecutive addresses starting from a loadable base. A read-back mode fetches N consecutive words for program verification.

## Interface
- `ADDR_W`, 32: OBI address width.
- `DATA_W`, 32: OBI data width; must be a multiple of 8.
- `FIFO_DEPTH`, 4: write-buffer depth in words; power of two, ≥2.
- `CNT_W`, 16: width of read-back word count.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req`, `we` out 1: OBI request and write enable.
- `be` out DATA_W/8: byte enables; all ones for every transfer.
- `addr` out ADDR_W: OBI address.
- `wdata` out DATA_W: OBI write data.
- `gnt`, `rvalid` in 1: OBI grant and response valid.
- `rdata` in DATA_W: OBI read data.
- `instr_valid` in 1: one-cycle pulse that pushes `instruction` into the FIFO.
- `instruction` in DATA_W: word to write.
- `addr_valid` in 1: one-cycle pulse that loads `new_section_address` into the address counter.
- `new_section_address` in ADDR_W: base address.
- `rd_start` in 1: one-cycle pulse that starts read-back of `rd_count` words.
- `rd_count` in CNT_W: number of words to read.
- `busy` out 1: bridge not idle.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH words.
- `overflow` out 1: sticky; a push was dropped. Cleared only by reset or `addr_valid`.
- `OBI_rvalid` out 1: one-cycle pulse with each read-back word.
- `OBI_rdata` out DATA_W: read-back word, registered and held until the next pulse.

## Operation
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP. Reset state is IDLE.
- IDLE → WREQ when FIFO is non-empty. Writes take priority over a pending read.
- IDLE → RREQ when the read-remaining counter is non-zero.
- WREQ: `req`=1, `we`=1, `addr`=counter, `wdata`=FIFO head. On `gnt`: pop the FIFO, go to WRESP.
- WRESP: on `rvalid`, counter += DATA_W/8. Then go to WREQ if the FIFO is non-empty, otherwise IDLE.
- RREQ: `req`=1, `we`=0, `addr`=counter. On `gnt`: go to RRESP.
- RRESP: on `rvalid`, capture `rdata` into `OBI_rdata`, pulse `OBI_rvalid`, counter += stride, remaining -= 1. Go to RREQ if remaining ≠ 0, otherwise IDLE.
- At most one outstanding transaction. `req`, `addr`, `we` and `wdata` are stable from `req` rise until `gnt`.
- Address counter wraps modulo 2^ADDR_W; no error is raised.
- FIFO push occurs when `instr_valid`=1 and the pre-edge count < FIFO_DEPTH, even if a pop happens in the same cycle.
- Push with pre-edge count = FIFO_DEPTH: word dropped, `overflow` set.
- `addr_valid` is accepted only when `busy`=0; it loads the counter and clears `overflow`. Ignored otherwise.
- `rd_start` is accepted only when `busy`=0 and the FIFO is empty; it loads remaining = `rd_count`. `rd_count`=0 is a no-op. Ignored otherwise.
- `addr_valid` and `rd_start` in the same idle cycle: both accepted; the read starts at the new base.
- `busy` = (state ≠ IDLE) or FIFO non-empty or remaining ≠ 0.
- Read-back responses arriving in a write state are not forwarded to `OBI_rvalid`.

## Timing
- Reset values: `req`=0, `we`=0, `be`=all ones, `addr`=0, `wdata`=0, `busy`=0, `fifo_full`=0, `overflow`=0, `OBI_rvalid`=0, `OBI_rdata`=0. FIFO is empty and remaining = 0.
- Reset asserted mid-transaction: return to IDLE immediately, drop FIFO contents and remaining count. Post-reset `rvalid` is ignored.
- Push at edge k: `busy`=1 after edge k; state WREQ after edge k+1, so `req`=1 in cycle k+1→k+2.
- With `gnt` in the first request cycle and `rvalid` one cycle later, a word costs 2 cycles. Back-to-back words give `req` high every other cycle.
- `OBI_rvalid` is asserted in the cycle after the `rvalid` edge, for exactly one cycle.
- `fifo_full` and `busy` are registered-state derived and have no combinational path from inputs.

## Test plan
- Reset, `addr_valid` base 0x0000_0180, push 0xDEADBEEF → one OBI write to 0x180 with `be`=0xF and `wdata`=0xDEADBEEF; `busy` falls after `rvalid`.
- Push 4 words with `gnt` held low → `fifo_full`=1. A 5th push sets `overflow` and is dropped. Release `gnt` → writes to base, +4, +8, +12 in order.
- `gnt` delayed 3 cycles and `rvalid` delayed 2 cycles → `addr`/`wdata`/`we` stable while `req`=1; exactly one outstanding request.
- Base 0xFFFF_FFFC, push 2 words → writes to 0xFFFF_FFFC then 0x0000_0000.
- Idle, base 0x100, `rd_start` with `rd_count`=3, memory returns 0xA,0xB,0xC → three reads at 0x100/0x104/0x108 and three `OBI_rvalid` pulses with the matching data. `rd_count`=0 → no request.
- Assert `rst` during WRESP with 2 words queued → all outputs at reset values next cycle; late `rvalid` causes no counter change and no `OBI_rvalid`.
